// File: rtl/lsu_hs_mmio.sv
`default_nettype none
// ============================================================================
// Module   : lsu_hs_mmio
// Brief    : Single-outstanding load/store unit with valid/ready handshakes
//            serving a data RAM, memory-mapped output registers and switches.
// Revision : 1.0
// ============================================================================
module lsu_hs_mmio #(
    parameter int DMEM_BYTES = 2048,
    parameter int IO_REGS    = 8,
    parameter int SW_SYNC    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_wren,
    input  logic [31:0]             i_req_addr,
    input  logic [31:0]             i_req_wdata,
    input  logic [1:0]              i_req_op,
    input  logic                    i_req_unsigned,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [31:0]             o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [32*IO_REGS-1:0]   o_io_out,
    input  logic [31:0]             i_io_sw
);
    localparam int C_AW    = $clog2(DMEM_BYTES);
    localparam int C_WORDS = DMEM_BYTES / 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        wren_q;
    logic        uns_q;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] io_q      [IO_REGS];
    logic [31:0] mem_q     [C_WORDS];
    logic [31:0] ram_rdata_q;
    logic [31:0] sw_sync_q [SW_SYNC];

    logic        w_in_ram;
    logic        w_in_io;
    logic        w_in_sw;
    logic        w_misal;
    logic        w_err;
    logic        w_store;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;
    logic [31:0] w_raw;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    // Decode of the captured request; only consumed while in S_ACCESS.
    always_comb begin
        w_in_ram = (addr_q[31:16] == 16'h0000) && (addr_q < 32'(DMEM_BYTES));
        w_in_io  = (addr_q[31:16] == 16'h1000) && ({28'd0, addr_q[15:12]} < 32'(IO_REGS));
        w_in_sw  = (addr_q[31:16] == 16'h1001);
        w_misal  = ((op_q == 2'b10) && addr_q[0]) || (!op_q[1] && (addr_q[1:0] != 2'b00));
        w_err    = !(w_in_ram || w_in_io || w_in_sw) || w_misal || (wren_q && w_in_sw);
        w_store  = wren_q && !w_err;

        if (!op_q[1]) begin
            w_be     = 4'b1111;
            w_wlanes = wdata_q;
        end else if (!op_q[0]) begin
            w_be     = addr_q[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{wdata_q[15:0]}};
        end else begin
            w_be     = 4'b0001 << addr_q[1:0];
            w_wlanes = {4{wdata_q[7:0]}};
        end

        w_raw = ram_rdata_q;
        if (w_in_sw) begin
            w_raw = sw_sync_q[SW_SYNC-1];
        end else if (w_in_io) begin
            for (int k = 0; k < IO_REGS; k++) begin
                if (addr_q[15:12] == 4'(k)) begin
                    w_raw = io_q[k];
                end
            end
        end

        // Alignment is guaranteed for non-error cases, so one shifter serves all sizes.
        w_shifted = w_raw >> {addr_q[1:0], 3'b000};
        if (!op_q[1]) begin
            w_load = w_shifted;
        end else if (!op_q[0]) begin
            w_load = uns_q ? {16'h0000, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
        end else begin
            w_load = uns_q ? {24'h000000, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            wren_q      <= 1'b0;
            uns_q       <= 1'b0;
            op_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            for (int k = 0; k < IO_REGS; k++) begin
                io_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid) begin
                        wren_q  <= i_req_wren;
                        uns_q   <= i_req_unsigned;
                        op_q    <= i_req_op;
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_store && w_in_io) begin
                        for (int k = 0; k < IO_REGS; k++) begin
                            if (addr_q[15:12] == 4'(k)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (w_be[b]) begin
                                        io_q[k][8*b +: 8] <= w_wlanes[8*b +: 8];
                                    end
                                end
                            end
                        end
                    end
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= w_err;
                    rsp_rdata_q <= (wren_q || w_err) ? 32'd0 : w_load;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset; its read port samples the incoming address on the accept edge.
    always_ff @(posedge i_clk) begin
        if ((state_q == S_ACCESS) && w_store && w_in_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[addr_q[C_AW-1:2]][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
        if ((state_q == S_IDLE) && i_req_valid) begin
            ram_rdata_q <= mem_q[i_req_addr[C_AW-1:2]];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < SW_SYNC; k++) begin
                sw_sync_q[k] <= '0;
            end
        end else begin
            sw_sync_q[0] <= i_io_sw;
            for (int k = 1; k < SW_SYNC; k++) begin
                sw_sync_q[k] <= sw_sync_q[k-1];
            end
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

    generate
        for (genvar k = 0; k < IO_REGS; k++) begin : g_io_out
            assign o_io_out[32*k +: 32] = io_q[k];
        end
    endgenerate
endmodule
`default_nettype wire
